// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state type and the
// default values of its configuration parameters.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'd100;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  // Redirect targets are forced to word alignment.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries. A push into a
// full FIFO is accepted only when a pop happens in the same cycle, so the
// count never exceeds DEPTH. Flush empties the FIFO and wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Qualify push/pop against occupancy and compute next pointers/count.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a combinational
// instruction memory, queues fetched words in a 2-entry FIFO for the decoder,
// stops on HALT_WORD and restarts from a redirect.
//
// Decoder handshake: instr_valid/instr_out/pc_out describe the queue head; an
// entry transfers (pop) in any cycle where instr_valid && instr_ready are both
// high at the rising edge. instr_valid never depends on instr_ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP   = fetch_pkg::PC_STEP,
  parameter logic [31:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr_out,
  output logic [31:0]  pc_out,
  output logic         halted,
  output fetch_state_e dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   count;
  logic [63:0]  head;
  logic         pop, push, flush, can_fetch;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  // A full queue still accepts a fetch when the head leaves this cycle.
  assign can_fetch   = (count != 2'd2) || pop;

  // Next-state, PC update and queue control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = align_pc(redirect_pc);
        end else if (can_fetch) begin
          if (imem_data == HALT_WORD) begin
            state_d = HALT;
          end else begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = align_pc(redirect_pc);
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({imem_data, pc_q}),
    .rdata_o (head),
    .count_o (count)
  );

  assign imem_addr   = pc_q;
  assign instr_out   = head[63:32];
  assign pc_out      = head[31:0];
  assign halted      = (state_q == HALT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] HALT_W  = 32'hFC00_0000;
  localparam logic [31:0] NO_HALT = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n, start, redirect_valid, instr_ready;
  logic [31:0]  redirect_pc, imem_addr, imem_data, instr_out, pc_out;
  logic         instr_valid, halted;
  fetch_state_e dbg_state;
  logic [31:0]  halt_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [63:0]  exp_q[$];
  logic [31:0]  m_pc;
  fetch_state_e m_state;
  logic [31:0]  got[$];

  // Clock / reset block.
  always #5 clk = ~clk;

  // Memory image: every word is derived from its address, except one
  // selectable address that holds the halt word.
  assign imem_data = (imem_addr == halt_addr) ? HALT_W : (imem_addr ^ 32'h5A5A_0000);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? HALT_W : (a ^ 32'h5A5A_0000);
  endfunction

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .halted         (halted),
    .dbg_state_o    (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs with the model's view of the current cycle.
  task automatic check_outputs();
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
    chk("imem_addr", imem_addr, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_state == HALT});
    chk("state", {30'd0, dbg_state}, {30'd0, m_state});
    if (exp_q.size() != 0) begin
      chk("instr_out", instr_out, exp_q[0][63:32]);
      chk("pc_out", pc_out, exp_q[0][31:0]);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit pop;
    int occ;
    logic [31:0] w;
    if (!rst_n) begin
      exp_q.delete();
      m_pc    = 32'd100;
      m_state = IDLE;
      return;
    end
    occ = exp_q.size();
    pop = (occ != 0) && instr_ready;
    if (pop) void'(exp_q.pop_front());
    case (m_state)
      IDLE: if (start) m_state = RUN;
      RUN: begin
        if (redirect_valid) begin
          exp_q.delete();
          m_pc = {redirect_pc[31:2], 2'b00};
        end else if (occ < 2 || pop) begin
          w = mem_word(m_pc);
          if (w == HALT_W) m_state = HALT;
          else begin
            exp_q.push_back({w, m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          exp_q.delete();
          m_pc    = {redirect_pc[31:2], 2'b00};
          m_state = RUN;
        end
      end
      default: m_state = IDLE;
    endcase
  endtask

  // Driver: check, update model, advance one clock; outputs settle #1 later.
  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; halt_addr = NO_HALT;
    m_pc = 32'd100; m_state = IDLE;
    @(posedge clk); #1;
    do_reset();

    // Reset values.
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", imem_addr, 32'd100);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);

    // Streaming with decoder always ready.
    instr_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("stream_pc", pc_out, 32'd100 + 32'(4 * k));
      chk("stream_instr", instr_out, (32'd100 + 32'(4 * k)) ^ 32'h5A5A_0000);
      cycle();
    end

    // Backpressure: queue fills, PC holds, then drains without gaps.
    do_reset();
    instr_ready = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    chk("stall_addr", imem_addr, 32'd108);
    chk("stall_head", pc_out, 32'd100);
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("drain_pc", pc_out, 32'd100 + 32'(4 * k));
      cycle();
    end

    // Redirect flushes a full queue and aligns the target.
    do_reset();
    instr_ready = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'd202;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_empty", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'd200);
    cycle();
    chk("redir_head", pc_out, 32'd200);

    // Halt word at 112 stops fetching; redirect resumes.
    do_reset();
    halt_addr = 32'd112; instr_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    got.delete();
    repeat (8) begin
      if (instr_valid && instr_ready) got.push_back(pc_out);
      cycle();
    end
    chk("halt_count", got.size(), 32'd3);
    for (int k = 0; k < got.size() && k < 3; k++)
      chk("halt_deliv", got[k], 32'd100 + 32'(4 * k));
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_addr", imem_addr, 32'd112);
    halt_addr = NO_HALT;
    redirect_valid = 1'b1; redirect_pc = 32'd100;
    cycle();
    redirect_valid = 1'b0;
    chk("resume_state", {30'd0, dbg_state}, {30'd0, RUN});
    chk("resume_addr", imem_addr, 32'd100);
    cycle();
    chk("resume_head", pc_out, 32'd100);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_zero", imem_addr, 32'd0);
    chk("wrap_head", pc_out, 32'hFFFF_FFFC);

    // Reset while full and stalled discards the queue.
    instr_ready = 1'b0;
    repeat (3) cycle();
    chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    do_reset();
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd100);
    chk("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    instr_ready = 1'b1;
    cycle();
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0)
        halt_addr = ($urandom_range(0, 1) == 0) ? NO_HALT : 32'd100 + 32'(4 * $urandom_range(2, 12));
      rst_n          = ($urandom_range(0, 79) != 0);
      start          = ($urandom_range(0, 5) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                   : (32'd96 + 32'($urandom_range(0, 40)));
      cycle();
    end
    rst_n = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd100, meaning the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd4, meaning the sequential PC increment.
REQ-003 SHALL have parameter HALT_WORD, default 32'hFC00_0000, meaning the instruction word that stops fetching.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: leaves IDLE and begins fetching.
REQ-007 SHALL have port imem_addr, output, 32 bits: address to the combinational instruction memory; equals the PC register.
REQ-008 SHALL have port imem_data, input, 32 bits: memory word at imem_addr, valid in the same cycle.
REQ-009 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-010 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-011 SHALL have port instr_valid, output, 1 bit: the queue head is valid.
REQ-012 SHALL have port instr_ready, input, 1 bit: the decoder accepts the head.
REQ-013 SHALL have port instr_out, output, 32 bits: the queue head instruction.
REQ-014 SHALL have port pc_out, output, 32 bits: the address the head was fetched from.
REQ-015 SHALL have port halted, output, 1 bit: high in state HALT.

Function
REQ-016 SHALL have FSM states IDLE, RUN and HALT.
REQ-017 SHALL make these FSM transitions: IDLE->RUN on start; RUN->HALT on a fetched HALT_WORD; HALT->RUN on redirect_valid; no other transitions.
REQ-018 SHALL hold a 2-entry FIFO of {instr, pc}; instr_valid = (count != 0).
REQ-019 SHALL define a pop as instr_valid && instr_ready in a cycle; pops SHALL be allowed in every state.
REQ-020 SHALL fetch in RUN when count < 2, or when count == 2 and a pop occurs in the same cycle: push {imem_data, PC}, then PC <= PC + PC_STEP.
REQ-021 SHALL make fetch latency one cycle: a word at address A is visible on instr_out the cycle after A is driven, if the FIFO was empty.
REQ-022 SHALL stall when the FIFO is full with no pop: no push, PC held, imem_addr stable.
REQ-023 SHALL, when the fetched word equals HALT_WORD in RUN: not push it, hold PC at that address, and enter HALT; queued entries drain normally.
REQ-024 SHALL give redirect_valid priority over fetch: FIFO flushed (count <= 0), PC <= {redirect_pc[31:2], 2'b00}, no push that cycle.
REQ-025 SHALL treat a pop coinciding with a redirect as completed by the decoder, while still flushing the remaining entries.
REQ-026 SHALL ignore redirect_valid in IDLE.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL wrap the PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0) with no error flag.
REQ-029 SHALL never make simultaneous push and pop at count == 2 overflow; count SHALL stay at 2.

Reset
REQ-030 SHALL, when rst_n == 0 at a clock edge, set: state IDLE, PC = RESET_PC, count = 0, FIFO pointers = 0.
REQ-031 SHALL have these output values after reset: instr_valid 0, halted 0, imem_addr RESET_PC, instr_out 0, pc_out 0.
REQ-032 SHALL let reset mid-operation, including during a stall or in HALT, discard all queued entries with no pop visible afterwards.

Structure
REQ-033 SHALL place the state enum (IDLE/RUN/HALT) and the default constants RESET_PC, PC_STEP and HALT_WORD in shared package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_fifo (parameterised width 64, depth 2, with push/pop/flush and count).

Verification
REQ-035 SHALL cover: reset, start, instr_ready=1, memory 100..116 loaded -> pc_out 100,104,108,112,116 on consecutive cycles after a 1-cycle latency.
REQ-036 SHALL cover: instr_ready=0 for 5 cycles from start -> two entries (100,104) queued, imem_addr held at 108; ready=1 -> 100,104,108 with no gap or duplicate.
REQ-037 SHALL cover: redirect_valid with redirect_pc=32'd202 while 2 entries are queued -> FIFO empty next cycle, imem_addr=200, next pc_out=200.
REQ-038 SHALL cover: HALT_WORD at 112 -> entries 100..108 delivered, 112 never delivered, halted=1, imem_addr stays 112; redirect to 100 -> RUN and fetch resumes at 100.
REQ-039 SHALL cover: redirect to 32'hFFFF_FFFC -> the following fetch address is 0.
REQ-040 SHALL cover: rst_n=0 for 1 cycle while full and stalled -> instr_valid=0, imem_addr=100, state IDLE.
